map_line_scheduler: RTL and testbench



---
 rtl/map_pkg.sv | 32 +++
 rtl/map_line_scheduler.sv | 121 ++++++++++++
 tb/tb_map_line_scheduler.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/map_pkg.sv
// Shared constants, colour codes and scheduler state encoding for the playfield map RAM.
package map_pkg;

    localparam int H_PIXELS       = 848;
    localparam int V_LINES        = 480;
    localparam int PIX_BITS       = 2;
    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = H_PIXELS * PIX_BITS / WORD_W;
    localparam int ADDR_W         = 15;
    localparam int VLINE_W        = 9;
    localparam int IDX_W          = 6;

    typedef enum logic [1:0] {
        COL_BLACK = 2'd0,
        COL_RED   = 2'd1,
        COL_GREEN = 2'd2,
        COL_BLUE  = 2'd3
    } colour_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BASE,
        ST_FETCH,
        ST_DRAIN
    } state_t;

    // First word address of a display line; the multiply is by a constant.
    function automatic logic [ADDR_W-1:0] line_base(input logic [VLINE_W-1:0] v);
        return ADDR_W'(v) * ADDR_W'(WORDS_PER_LINE);
    endfunction

endpackage

// File: rtl/map_line_scheduler.sv
// Map RAM owner: one line prefetch per display line into the line buffer, game writer gets idle cycles.
// Build option MAP_WRITER_SLOT_EN: every 4th FETCH cycle is offered to the writer.
module map_line_scheduler
    import map_pkg::*;
(
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                new_line,
    input  logic [VLINE_W-1:0]  next_vline,
    input  logic                wr_req,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [WORD_W-1:0]   wr_data,
    output logic                wr_gnt,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [WORD_W-1:0]   mem_wdata,
    input  logic [WORD_W-1:0]   mem_rdata,
    output logic                lb_we,
    output logic [IDX_W-1:0]    lb_idx,
    output logic [WORD_W-1:0]   lb_data,
    output logic                line_ready,
    output logic                overrun
);

    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(WORDS_PER_LINE - 1);

    state_t              state, state_nxt;
    logic [VLINE_W-1:0]  vline_q;
    logic [ADDR_W-1:0]   base_q;
    logic                blank_q;
    logic [IDX_W-1:0]    k_q;
    logic [1:0]          slot_q;
    logic                issue;
    logic                abort;

    assign abort = new_line && (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        wr_gnt    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        issue     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (new_line) begin
                    state_nxt = ST_BASE;
                end else if (wr_req) begin
                    wr_gnt    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = wr_addr;
                    mem_wdata = wr_data;
                end
            end
            ST_BASE: state_nxt = ST_FETCH;
            ST_FETCH: begin
`ifdef MAP_WRITER_SLOT_EN
                if (slot_q == 2'd3 && wr_req) begin
                    wr_gnt    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = wr_addr;
                    mem_wdata = wr_data;
                end else begin
                    issue    = 1'b1;
                    mem_addr = blank_q ? '0 : base_q + ADDR_W'(k_q);
                end
`else
                issue    = 1'b1;
                mem_addr = blank_q ? '0 : base_q + ADDR_W'(k_q);
`endif
                if (issue && k_q == LAST_K) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (abort) state_nxt = ST_BASE;
        // Keep the RAM port quiet while reset is asserted, even with a request pending.
        if (!RST_N) begin
            wr_gnt    = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            vline_q    <= '0;
            base_q     <= '0;
            blank_q    <= 1'b0;
            k_q        <= '0;
            slot_q     <= '0;
            lb_we      <= 1'b0;
            lb_idx     <= '0;
            line_ready <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (new_line) vline_q <= next_vline;
            if (state == ST_BASE) begin
                base_q  <= line_base(vline_q);
                blank_q <= (vline_q >= VLINE_W'(V_LINES));
                k_q     <= '0;
                slot_q  <= '0;
            end else if (state == ST_FETCH) begin
                slot_q <= slot_q + 2'd1;
                if (issue) k_q <= k_q + IDX_W'(1);
            end
            // An aborted fetch must not deliver the word issued in the abort cycle.
            lb_we      <= issue && !abort;
            lb_idx     <= issue ? k_q : '0;
            line_ready <= (state == ST_DRAIN) && !new_line;
            overrun    <= overrun | abort;
        end
    end

    assign lb_data = (lb_we && !blank_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_map_line_scheduler.sv
// Directed bench for map_line_scheduler with a behavioural 1-cycle-latency map RAM.
module tb_map_line_scheduler;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        new_line = 1'b0;
    logic [8:0]  next_vline = '0;
    logic        wr_req = 1'b0;
    logic [14:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        wr_gnt;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        lb_we;
    logic [5:0]  lb_idx;
    logic [31:0] lb_data;
    logic        line_ready;
    logic        overrun;

    logic [31:0] ram [0:32767];
    int vecs = 0;
    int errs = 0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    map_line_scheduler dut (
        .CLK(CLK), .RST_N(RST_N), .new_line(new_line), .next_vline(next_vline),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .lb_we(lb_we), .lb_idx(lb_idx), .lb_data(lb_data),
        .line_ready(line_ready), .overrun(overrun)
    );

    // Drive a line strobe in a fresh cycle (cycle 0) and sample it at the negedge.
    task automatic strobe(input int v);
        @(posedge CLK); #1;
        new_line   = 1'b1;
        next_vline = 9'(v);
        @(negedge CLK);
    endtask

    // Check cycles 1..57 after a strobe at cycle 0 for line v.
    task automatic check_line(input int v, input string tag);
        bit blank;
        int base;
        blank = (v >= 480);
        base  = v * 53;
        for (int c = 1; c <= 57; c++) begin
            @(posedge CLK); #1;
            new_line = 1'b0;
            @(negedge CLK);
            if (c >= 2 && c <= 54) begin
                vecs++;
                if (mem_addr !== 15'(blank ? 0 : base + c - 2) || mem_we !== 1'b0) begin
                    errs++;
                    $display("FAIL %s addr c=%0d got %0d we=%b want %0d", tag, c, mem_addr, mem_we,
                             blank ? 0 : base + c - 2);
                end
            end
            vecs++;
            if (c >= 3 && c <= 55) begin
                if (lb_we !== 1'b1 || lb_idx !== 6'(c - 3) || lb_data !== 32'(blank ? 0 : base + c - 3)) begin
                    errs++;
                    $display("FAIL %s lb c=%0d got we=%b idx=%0d data=%0d want idx=%0d data=%0d", tag, c,
                             lb_we, lb_idx, lb_data, c - 3, blank ? 0 : base + c - 3);
                end
            end else if (lb_we !== 1'b0) begin
                errs++;
                $display("FAIL %s lb_we c=%0d got %b want 0", tag, c, lb_we);
            end
            vecs++;
            if (line_ready !== (c == 56)) begin
                errs++;
                $display("FAIL %s line_ready c=%0d got %b want %b", tag, c, line_ready, c == 56);
            end
        end
    endtask

    task automatic test_reset;
        #2;
        vecs++;
        if ({wr_gnt, mem_we, mem_addr, mem_wdata, lb_we, lb_idx, lb_data, line_ready, overrun} !== '0) begin
            errs++;
            $display("FAIL reset outputs got gnt=%b we=%b addr=%0d lb_we=%b idx=%0d rdy=%b ovr=%b want all 0",
                     wr_gnt, mem_we, mem_addr, lb_we, lb_idx, line_ready, overrun);
        end
        @(negedge CLK); RST_N = 1'b1;
    endtask

    task automatic test_fetch;
        strobe(2);
        check_line(2, "fetch_v2");
    endtask

    task automatic test_blank;
        strobe(480);
        check_line(480, "blank_v480");
    endtask

    task automatic test_writer_stall;
        int first = -1;
        strobe(1);
        for (int c = 1; c <= 60; c++) begin
            @(posedge CLK); #1;
            new_line = 1'b0;
            if (c == 1) begin
                wr_req = 1'b1; wr_addr = 15'h0010; wr_data = 32'hDEADBEEF;
            end
            if (first >= 0) wr_req = 1'b0;
            @(negedge CLK);
            if (wr_gnt === 1'b1 && first < 0) begin
                first = c;
                vecs++;
                if (mem_we !== 1'b1 || mem_addr !== 15'h0010 || mem_wdata !== 32'hDEADBEEF) begin
                    errs++;
                    $display("FAIL wr_port got we=%b addr=%h data=%h want 1/0010/deadbeef", mem_we, mem_addr, mem_wdata);
                end
            end
        end
        vecs++;
        if (first != 56) begin
            errs++;
            $display("FAIL wr_stall first grant cycle got %0d want 56", first);
        end
        vecs++;
        if (ram[16] !== 32'hDEADBEEF) begin
            errs++;
            $display("FAIL wr_commit ram[0x10] got %h want deadbeef", ram[16]);
        end
    endtask

    task automatic test_overrun;
        @(posedge CLK); #1;
        new_line = 1'b1; next_vline = 9'd3;
        wr_req = 1'b1; wr_addr = 15'h0020; wr_data = 32'h5;
        @(negedge CLK);
        vecs++;
        if (wr_gnt !== 1'b0 || mem_we !== 1'b0) begin
            errs++;
            $display("FAIL collide_gnt got gnt=%b we=%b want 0/0", wr_gnt, mem_we);
        end
        for (int c = 1; c <= 29; c++) begin
            @(posedge CLK); #1;
            new_line = 1'b0; wr_req = 1'b0;
            @(negedge CLK);
        end
        vecs++;
        if (overrun !== 1'b0) begin
            errs++;
            $display("FAIL overrun_pre got %b want 0", overrun);
        end
        strobe(4);
        check_line(4, "restart_v4");
        vecs++;
        if (overrun !== 1'b1) begin
            errs++;
            $display("FAIL overrun_sticky got %b want 1", overrun);
        end
    endtask

    task automatic test_reset_mid_fetch;
        strobe(2);
        for (int c = 1; c <= 22; c++) begin
            @(posedge CLK); #1;
            new_line = 1'b0;
            @(negedge CLK);
        end
        vecs++;
        if (mem_addr !== 15'd126) begin
            errs++;
            $display("FAIL mid_fetch addr k=20 got %0d want 126", mem_addr);
        end
        RST_N = 1'b0;
        #1;
        vecs++;
        if ({wr_gnt, mem_we, mem_addr, mem_wdata, lb_we, lb_idx, lb_data, line_ready, overrun} !== '0) begin
            errs++;
            $display("FAIL mid_reset outputs got we=%b addr=%0d lb_we=%b idx=%0d rdy=%b ovr=%b want all 0",
                     mem_we, mem_addr, lb_we, lb_idx, line_ready, overrun);
        end
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge CLK);
            vecs++;
            if (lb_we !== 1'b0 || line_ready !== 1'b0) begin
                errs++;
                $display("FAIL post_reset c=%0d got lb_we=%b rdy=%b want 0/0", c, lb_we, line_ready);
            end
        end
        @(posedge CLK); #1;
        wr_req = 1'b1; wr_addr = 15'h0030; wr_data = 32'h1234;
        @(negedge CLK);
        vecs++;
        if (wr_gnt !== 1'b1 || mem_addr !== 15'h0030) begin
            errs++;
            $display("FAIL post_reset_idle gnt got %b addr %h want 1/0030", wr_gnt, mem_addr);
        end
        @(posedge CLK); #1;
        wr_req = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        for (int n = 0; n < 32768; n++) ram[n] = 32'(n);
        test_reset;
        test_fetch;
        test_blank;
        test_writer_stall;
        test_overrun;
        test_reset_mid_fetch;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
